// File: rtl/ex_mem_pipe_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem_pipe_stage_pkg
//  Purpose  : Shared definitions for the EX->MEM pipeline register:
//             control-vector bit positions, control width, reset pc.
//  Revision : 1.0  initial release
// ============================================================================
package ex_mem_pipe_stage_pkg;

    // Control vector layout {jump,branch,memWrite,regWrite,memToReg}
    localparam int CTRL_MEMTOREG = 0;
    localparam int CTRL_REGWRITE = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_BRANCH   = 3;
    localparam int CTRL_JUMP     = 4;

    localparam int          EM_CTRL_W   = 5;
    localparam logic [31:0] EM_RESET_PC = 32'h0000_3000;

endpackage
`default_nettype wire

// File: rtl/ex_mem_pipe_stage_slot.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_slot
//  Purpose  : One payload entry of the EX->MEM stage. Loads on an accepted
//             beat, otherwise holds; a synchronous clear restores RESET_VAL.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_slot
    import ex_mem_pipe_stage_pkg::*;
#(
    parameter int               PAY_W     = 8,
    parameter logic [PAY_W-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic [PAY_W-1:0] d,
    output logic [PAY_W-1:0] q
);

    // Clear has priority so reset/flush always wins over a same-cycle load
    always_ff @(posedge clk) begin
        if (clear) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_mem_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem_pipe_stage
//  Purpose  : EX->MEM pipeline register with valid/ready handshake, optional
//             second (skid) entry and synchronous flush. Bubbles present an
//             all-zero control vector so no write enable fires spuriously.
//  Revision : 1.0  initial release
// ============================================================================
module ex_mem_pipe_stage
    import ex_mem_pipe_stage_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                RADDR_W  = 5,
    parameter int                CTRL_W   = EM_CTRL_W,
    parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(EM_RESET_PC),
    parameter int                SKID     = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_pc,
    input  logic [RADDR_W-1:0] in_regaddr,
    input  logic [DATA_W-1:0]  in_alures,
    input  logic [DATA_W-1:0]  in_rdata2,
    input  logic [CTRL_W-1:0]  in_ctrl,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_pc,
    output logic [RADDR_W-1:0] out_regaddr,
    output logic [DATA_W-1:0]  out_alures,
    output logic [DATA_W-1:0]  out_rdata2,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [1:0]         occupancy
);

    localparam int               PAY_W     = 3*DATA_W + RADDR_W + CTRL_W;
    localparam logic [PAY_W-1:0] PAY_RESET = {RESET_PC, {(PAY_W-DATA_W){1'b0}}};

    // State encoding doubles as the occupancy count
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             in_fire;
    logic             out_fire;
    logic             head_load;
    logic             head_from_skid;
    logic             skid_load;
    logic             clear;
    logic [PAY_W-1:0] in_pay;
    logic [PAY_W-1:0] head_d;
    logic [PAY_W-1:0] head_q;
    logic [PAY_W-1:0] skid_q;
    logic [CTRL_W-1:0] head_ctrl;

    assign out_valid = (state != ST_EMPTY);
    assign occupancy = state;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign clear     = reset | flush;
    assign in_pay    = {in_pc, in_regaddr, in_alures, in_rdata2, in_ctrl};

    // With a skid entry in_ready comes straight from the state flops;
    // without one it must look at out_ready to sustain full throughput.
    generate
        if (SKID != 0) begin : g_ready_skid
            assign in_ready = !reset && (state != ST_TWO);
        end else begin : g_ready_noskid
            assign in_ready = !reset && (!out_valid || out_ready);
        end
    endgenerate

    // Next-state and slot-load decode; head refills from skid when draining TWO
    always_comb begin
        state_nxt      = state;
        head_load      = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_nxt = ST_ONE;
                    head_load = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    head_load = 1'b1;
                end else if (in_fire) begin
                    state_nxt = ST_TWO;
                    skid_load = 1'b1;
                end else if (out_fire) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    state_nxt      = ST_ONE;
                    head_load      = 1'b1;
                    head_from_skid = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Reset and flush both empty the stage; the flushed in beat is dropped
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    assign head_d = head_from_skid ? skid_q : in_pay;

    pipe_slot #(
        .PAY_W     (PAY_W),
        .RESET_VAL (PAY_RESET)
    ) u_head (
        .clk   (clk),
        .clear (clear),
        .load  (head_load),
        .d     (head_d),
        .q     (head_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(
                .PAY_W     (PAY_W),
                .RESET_VAL (PAY_RESET)
            ) u_skid (
                .clk   (clk),
                .clear (clear),
                .load  (skid_load),
                .d     (in_pay),
                .q     (skid_q)
            );
        end else begin : g_no_skid
            assign skid_q = PAY_RESET;
        end
    endgenerate

    assign {out_pc, out_regaddr, out_alures, out_rdata2, head_ctrl} = head_q;
    assign out_ctrl = head_ctrl & {CTRL_W{out_valid}};

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_mem_pipe_stage
//  Purpose  : Directed self-checking bench for ex_mem_pipe_stage, covering
//             the skid build (a_*) and the single-entry build (b_*).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_mem_pipe_stage;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;

    // SKID=1 instance
    logic        a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
    logic [31:0] a_in_pc = 0, a_in_alures = 0, a_in_rdata2 = 0;
    logic [4:0]  a_in_regaddr = 0, a_in_ctrl = 0;
    logic [31:0] a_out_pc, a_out_alures, a_out_rdata2;
    logic [4:0]  a_out_regaddr, a_out_ctrl;
    logic [1:0]  a_occ;

    // SKID=0 instance
    logic        b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
    logic [31:0] b_in_pc = 0, b_in_alures = 0, b_in_rdata2 = 0;
    logic [4:0]  b_in_regaddr = 0, b_in_ctrl = 0;
    logic [31:0] b_out_pc, b_out_alures, b_out_rdata2;
    logic [4:0]  b_out_regaddr, b_out_ctrl;
    logic [1:0]  b_occ;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ex_mem_pipe_stage #(.SKID(1)) u_dut_skid (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_pc(a_in_pc), .in_regaddr(a_in_regaddr), .in_alures(a_in_alures),
        .in_rdata2(a_in_rdata2), .in_ctrl(a_in_ctrl),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_pc(a_out_pc), .out_regaddr(a_out_regaddr), .out_alures(a_out_alures),
        .out_rdata2(a_out_rdata2), .out_ctrl(a_out_ctrl), .occupancy(a_occ)
    );

    ex_mem_pipe_stage #(.SKID(0)) u_dut_noskid (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_pc(b_in_pc), .in_regaddr(b_in_regaddr), .in_alures(b_in_alures),
        .in_rdata2(b_in_rdata2), .in_ctrl(b_in_ctrl),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_pc(b_out_pc), .out_regaddr(b_out_regaddr), .out_alures(b_out_alures),
        .out_rdata2(b_out_rdata2), .out_ctrl(b_out_ctrl), .occupancy(b_occ)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle and settle just past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] sb[$];
    logic [31:0] exp_pc;
    int          sent;
    int          rcvd;
    logic [31:0] next_pc;
    logic        exp_ready;

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_occ",      a_occ, 0);
        check("rst_valid",    a_out_valid, 0);
        check("rst_pc",       a_out_pc, 32'h3000);
        check("rst_ctrl",     a_out_ctrl, 0);
        check("rst_alures",   a_out_alures, 0);
        check("rst_inready",  a_in_ready, 0);
        check("rst_b_inready", b_in_ready, 0);
        reset = 1'b0;
        #1;
        check("post_rst_inready",   a_in_ready, 1);
        check("post_rst_b_inready", b_in_ready, 1);

        // ---------------- pass-through ----------------
        a_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_in_valid   = 1'b1;
            a_in_pc      = 32'h3000 + 32'(4*k);
            a_in_regaddr = 5'(k + 1);
            a_in_alures  = 32'hA000 + 32'(k);
            a_in_rdata2  = 32'hD000 + 32'(k);
            a_in_ctrl    = 5'b00010;
            #1;
            check("pt_inready", a_in_ready, 1);
            tick();
            check("pt_valid",   a_out_valid, 1);
            check("pt_pc",      a_out_pc, 32'h3000 + 32'(4*k));
            check("pt_regaddr", a_out_regaddr, 5'(k + 1));
            check("pt_alures",  a_out_alures, 32'hA000 + 32'(k));
            check("pt_rdata2",  a_out_rdata2, 32'hD000 + 32'(k));
            check("pt_ctrl",    a_out_ctrl, 5'b00010);
            check("pt_occ",     a_occ, 1);
        end
        a_in_valid = 1'b0;
        tick();
        check("pt_drain_valid", a_out_valid, 0);
        check("pt_drain_ctrl",  a_out_ctrl, 0);
        check("pt_drain_occ",   a_occ, 0);

        // ---------------- back-pressure ----------------
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_ctrl   = 5'b00001;
        a_in_pc     = 32'h3000;
        tick();
        check("bp_occ1",     a_occ, 1);
        check("bp_pc1",      a_out_pc, 32'h3000);
        check("bp_inready1", a_in_ready, 1);
        a_in_pc = 32'h3004;
        tick();
        check("bp_occ2",     a_occ, 2);
        check("bp_inready2", a_in_ready, 0);
        check("bp_pc2",      a_out_pc, 32'h3000);
        a_in_pc = 32'h3008;
        tick();
        check("bp_occ3", a_occ, 2);
        check("bp_pc3",  a_out_pc, 32'h3000);
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        #1;
        check("bp_rel_valid", a_out_valid, 1);
        check("bp_rel_pc0",   a_out_pc, 32'h3000);
        tick();
        check("bp_rel_pc1",   a_out_pc, 32'h3004);
        check("bp_rel_occ1",  a_occ, 1);
        tick();
        check("bp_rel_occ0",  a_occ, 0);
        check("bp_rel_valid0", a_out_valid, 0);

        // ---------------- bubble gating ----------------
        a_in_valid = 1'b0;
        a_in_ctrl  = 5'b11111;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bub_valid", a_out_valid, 0);
            check("bub_ctrl",  a_out_ctrl, 0);
        end

        // ---------------- flush while holding two ----------------
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_ctrl   = 5'b00110;
        a_in_alures = 32'h1234_5678;
        a_in_pc     = 32'h3010;
        tick();
        a_in_pc = 32'h3014;
        tick();
        check("fl_occ_pre", a_occ, 2);
        flush   = 1'b1;
        a_in_pc = 32'h3020;
        tick();
        check("fl_occ",    a_occ, 0);
        check("fl_valid",  a_out_valid, 0);
        check("fl_pc",     a_out_pc, 32'h3000);
        check("fl_alures", a_out_alures, 0);
        check("fl_ctrl",   a_out_ctrl, 0);
        flush      = 1'b0;
        a_in_valid = 1'b0;
        #1;
        check("fl_inready", a_in_ready, 1);
        a_out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("fl_no_emit", a_out_valid, 0);
        end

        // ---------------- reset mid-stream ----------------
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_ctrl   = 5'b11111;
        a_in_pc     = 32'h3040;
        tick();
        a_in_pc = 32'h3044;
        tick();
        check("mr_occ_pre", a_occ, 2);
        reset      = 1'b1;
        a_in_valid = 1'b0;
        tick();
        check("mr_pc",   a_out_pc, 32'h3000);
        check("mr_ctrl", a_out_ctrl, 0);
        check("mr_occ",  a_occ, 0);
        reset = 1'b0;
        #1;
        check("mr_inready", a_in_ready, 1);

        // ---------------- SKID=0: toggled out_ready ----------------
        sent    = 0;
        rcvd    = 0;
        next_pc = 32'h3000;
        b_in_ctrl = 5'b00010;
        for (int k = 0; k < 12; k++) begin
            b_out_ready = (k % 2 == 0);
            b_in_valid  = 1'b1;
            b_in_pc     = next_pc;
            #1;
            exp_ready = (sb.size() == 0) || b_out_ready;
            check("ns_inready", b_in_ready, exp_ready);
            check("ns_valid",   b_out_valid, sb.size() != 0);
            if (b_out_valid && b_out_ready && sb.size() != 0) begin
                exp_pc = sb.pop_front();
                check("ns_pc", b_out_pc, exp_pc);
                rcvd++;
            end
            if (b_in_ready) begin
                sb.push_back(next_pc);
                next_pc = next_pc + 32'd4;
                sent++;
            end
            tick();
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (b_out_valid && sb.size() != 0) begin
                exp_pc = sb.pop_front();
                check("ns_drain_pc", b_out_pc, exp_pc);
                rcvd++;
            end
            tick();
        end
        check("ns_count",  rcvd, sent);
        check("ns_min",    sent >= 6, 1);
        check("ns_empty",  b_occ, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
